// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared external bus to one of DMA, PPU or CPU each cycle.
// DMA owns the bus for a whole transfer but lets CPU HRAM accesses through; the
// PPU is forced to yield one cycle to a waiting CPU after MAX_HOLD owned cycles.
module mem_arbiter #(
  parameter logic [15:0] HRAM_LO  = 16'hFF80,
  parameter logic [15:0] HRAM_HI  = 16'hFFFE,
  parameter int          MAX_HOLD = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic        dma_req,
  input  logic        ppu_req,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic        dma_gnt,
  output logic        ppu_gnt,
  output logic [1:0]  bus_owner,
  output logic [15:0] stall_count
);

  // State encoding doubles as the bus_owner value.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2,
    ST_PPU  = 2'd3
  } state_t;

  // Hold counter needs at least one bit even when MAX_HOLD is 1.
  localparam int             HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_next;
  logic [15:0]   r_stall_count;
  logic          w_hram_hit;
  logic          w_fair_hit;
  logic          w_cpu_gnt;
  logic          w_cpu_stall;

  // Next-state priority (DMA > PPU fairness slot > PPU > CPU > idle) and hold counter update.
  always_comb begin
    w_hram_hit   = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
    w_fair_hit   = (r_state == ST_PPU) && cpu_req && (r_hold == HOLD_LAST);
    w_next_state = ST_IDLE;
    w_hold_next  = '0;

    if (dma_req) begin
      w_next_state = ST_DMA;
    end else if (w_fair_hit) begin
      w_next_state = ST_CPU;
    end else if (ppu_req) begin
      w_next_state = ST_PPU;
    end else if (cpu_req) begin
      w_next_state = ST_CPU;
    end else begin
      w_next_state = ST_IDLE;
    end

    // The counter only runs while the PPU keeps a requesting CPU waiting; it
    // restarts once the fairness slot comes due.
    if ((r_state == ST_PPU) && cpu_req && !w_fair_hit) begin
      w_hold_next = r_hold + HW'(1);
    end else begin
      w_hold_next = '0;
    end
  end

  // Grant and stall decode; stall is masked during reset so outputs drop at once.
  always_comb begin
    w_cpu_gnt   = (r_state == ST_CPU) ||
                  ((r_state == ST_DMA) && cpu_req && w_hram_hit);
    w_cpu_stall = cpu_req && !w_cpu_gnt && !reset;
  end

  // State register and hold counter, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_next_state;
      r_hold  <= w_hold_next;
    end
  end

  // Saturating count of stalled CPU cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_count <= 16'h0000;
    end else if (w_cpu_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'h0001;
    end else begin
      r_stall_count <= r_stall_count;
    end
  end

  assign cpu_gnt     = w_cpu_gnt;
  assign cpu_stall   = w_cpu_stall;
  assign dma_gnt     = (r_state == ST_DMA);
  assign ppu_gnt     = (r_state == ST_PPU);
  assign bus_owner   = r_state;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized stimulus checked against a cycle model
// of the arbitration rules (owner, hold cycles, stall total kept as plain ints).
module tb_mem_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        dma_req;
  logic        ppu_req;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic        dma_gnt;
  logic        ppu_gnt;
  logic [1:0]  bus_owner;
  logic [15:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 CPU, 2 DMA, 3 PPU.
  int m_owner = 0;
  int m_hold  = 0;
  int m_stall = 0;

  mem_arbiter #(
    .HRAM_LO (16'hFF80),
    .HRAM_HI (16'hFFFE),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .dma_req    (dma_req),
    .ppu_req    (ppu_req),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .dma_gnt    (dma_gnt),
    .ppu_gnt    (ppu_gnt),
    .bus_owner  (bus_owner),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit model_hram();
    return (int'(cpu_addr) >= 32'hFF80) && (int'(cpu_addr) <= 32'hFFFE);
  endfunction

  function automatic bit model_cpu_gnt();
    return (m_owner == 1) || ((m_owner == 2) && cpu_req && model_hram());
  endfunction

  function automatic bit model_stall();
    return !reset && cpu_req && !model_cpu_gnt();
  endfunction

  task automatic check_outputs();
    check("bus_owner",   32'(bus_owner),   32'(m_owner));
    check("dma_gnt",     32'(dma_gnt),     32'(m_owner == 2));
    check("ppu_gnt",     32'(ppu_gnt),     32'(m_owner == 3));
    check("cpu_gnt",     32'(cpu_gnt),     32'(model_cpu_gnt()));
    check("cpu_stall",   32'(cpu_stall),   32'(model_stall()));
    check("stall_count", 32'(stall_count), 32'(m_stall));
  endtask

  // One bus cycle: drive at negedge, check, then advance the model at posedge.
  task automatic step(input bit d, input bit p, input bit c, input logic [15:0] a);
    bit fair;
    @(negedge clock);
    dma_req  = d;
    ppu_req  = p;
    cpu_req  = c;
    cpu_addr = a;
    #1;
    check_outputs();
    @(posedge clock);
    if (model_stall() && m_stall < 65535) m_stall++;
    fair = (m_owner == 3) && c && (m_hold == MAX_HOLD - 1);
    if ((m_owner == 3) && c && !fair) m_hold++;
    else m_hold = 0;
    if (d)         m_owner = 2;
    else if (fair) m_owner = 1;
    else if (p)    m_owner = 3;
    else if (c)    m_owner = 1;
    else           m_owner = 0;
  endtask

  // Zero inputs, reset the model, release reset at a negedge.
  task automatic release_reset();
    dma_req = 1'b0;
    ppu_req = 1'b0;
    cpu_req = 1'b0;
    m_owner = 0;
    m_hold  = 0;
    m_stall = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    release_reset();
  endtask

  initial begin
    bit d;
    bit p;
    bit c;
    logic [15:0] a;
    logic [15:0] addrs [6];
    addrs[0] = 16'hC000; addrs[1] = 16'hFF80; addrs[2] = 16'hFF90;
    addrs[3] = 16'hFFFE; addrs[4] = 16'hFFFF; addrs[5] = 16'h8000;

    // Power-on reset with a pending CPU request: everything must read zero.
    reset = 1'b1; dma_req = 1'b0; ppu_req = 1'b0; cpu_req = 1'b1; cpu_addr = 16'hC000;
    #3;
    check_outputs();
    release_reset();

    // CPU alone from idle: stalled in the first cycle, granted the next.
    step(1'b0, 1'b0, 1'b1, 16'hC000);
    #1 check("cpu_first_owner", 32'(bus_owner), 32'd1);
    step(1'b0, 1'b0, 1'b1, 16'hC000);
    step(1'b0, 1'b0, 1'b0, 16'hC000);
    #1 check("cpu_drop_idle", 32'(bus_owner), 32'd0);

    // CPU owns, DMA arrives; HRAM window boundaries while DMA holds the bus.
    step(1'b0, 1'b0, 1'b1, 16'hC000);
    step(1'b1, 1'b0, 1'b1, 16'hC000);
    #1 check("dma_preempt", 32'(bus_owner), 32'd2);
    step(1'b1, 1'b0, 1'b1, 16'hC000);
    step(1'b1, 1'b0, 1'b1, 16'hFF90);
    step(1'b1, 1'b0, 1'b1, 16'hFF80);
    step(1'b1, 1'b0, 1'b1, 16'hFFFE);
    step(1'b1, 1'b0, 1'b1, 16'hFFFF);
    step(1'b1, 1'b0, 1'b1, 16'hFF7F);

    // Reset between edges while DMA owns the bus.
    #2 check("dma_before_reset", 32'(dma_gnt), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_dma_gnt",   32'(dma_gnt),     32'd0);
    check("rst_owner",     32'(bus_owner),   32'd0);
    check("rst_stall",     32'(cpu_stall),   32'd0);
    check("rst_stall_cnt", 32'(stall_count), 32'd0);
    release_reset();

    // PPU and CPU both held: 8 PPU cycles then one CPU cycle, repeating.
    for (int k = 0; k < 36; k++) begin
      step(1'b0, 1'b1, 1'b1, 16'hC000);
      #1 check("fair_pattern", 32'(bus_owner), ((k % 9) < 8) ? 32'd3 : 32'd1);
    end
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1, 16'hC000);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 1'b1, 16'hC000);

    // All three from idle: DMA first, then PPU once DMA drops.
    apply_reset();
    step(1'b1, 1'b1, 1'b1, 16'h8000);
    #1 check("all3_dma", 32'(bus_owner), 32'd2);
    step(1'b0, 1'b1, 1'b1, 16'h8000);
    #1 check("all3_ppu", 32'(bus_owner), 32'd3);

    // Randomized traffic with a sticky DMA request.
    d = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) d = ~d;
      p = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 2) != 0);
      a = ($urandom_range(0, 7) < 6) ? addrs[$urandom_range(0, 5)] : 16'($urandom);
      step(d, p, c, a);
      if ($urandom_range(0, 999) == 0) apply_reset();
    end

    // Stall counter saturation under a long DMA with a non-HRAM CPU request.
    apply_reset();
    for (int k = 0; k < 70000; k++) step(1'b1, 1'b0, 1'b1, 16'h8000);
    #1 check("stall_saturate", 32'(stall_count), 32'h0000FFFF);
    step(1'b1, 1'b0, 1'b1, 16'h8000);
    #1 check("stall_hold", 32'(stall_count), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
